// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 access codes,
// opcodes shared with the ALU decoder, FSM encoding and access legality helpers.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] encodes the access size for both signed and unsigned forms
  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return !lo[0];
      2'b10:   return lo == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Combinational load extraction: picks the byte/halfword lane from a memory word
// and sign- or zero-extends it to 32 bits.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = '0;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_W:    data = rdata;
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores over a req/ack data
// memory port, with fault reporting for misaligned, illegal and timed-out accesses.
//
// state | meaning
// IDLE  | ready for a request; illegal/misaligned goes straight to DONE
// REQ   | mem_req held until mem_ack or TIMEOUT cycles elapse
// DONE  | one-cycle done pulse, fault/ReadData valid
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ls_valid,
  output logic        ls_ready,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        done,
  output logic        fault,
  output logic [31:0] ReadData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_e       state_q;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [1:0]       addr_lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             done_q, fault_q, mem_req_q, mem_we_q;
  logic [31:0]      read_data_q, mem_addr_q, mem_wdata_q;
  logic [3:0]       mem_be_q;

  logic [3:0]       be_d;
  logic [31:0]      wdata_d;
  logic             access_ok;
  logic [31:0]      ld_data;

  always_comb begin
    be_d    = '0;
    wdata_d = '0;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << ALUResult[1:0];
        wdata_d = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << ALUResult[1:0];
        wdata_d = {2{WriteData[15:0]}};
      end
      2'b10: begin
        be_d    = 4'b1111;
        wdata_d = WriteData;
      end
      default: ;
    endcase
  end

  assign access_ok = f3_legal(MemWrite, funct3) && is_aligned(funct3, ALUResult[1:0]);
  assign cnt_d     = cnt_q + CNT_W'(1);

  load_align u_load_align (
    .funct3 (f3_q),
    .addr_lo(addr_lo_q),
    .rdata  (mem_rdata),
    .data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_lo_q   <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      read_data_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ls_valid) begin
            we_q        <= MemWrite;
            f3_q        <= funct3;
            addr_lo_q   <= ALUResult[1:0];
            mem_addr_q  <= {ALUResult[31:2], 2'b00};
            mem_be_q    <= be_d;
            mem_wdata_q <= wdata_d;
            cnt_q       <= '0;
            read_data_q <= '0;
            if (access_ok) begin
              state_q   <= ST_REQ;
              mem_req_q <= 1'b1;
              mem_we_q  <= MemWrite;
              fault_q   <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_d;
          // ack beats a simultaneous timeout
          if (mem_ack) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            fault_q     <= 1'b0;
            read_data_q <= we_q ? 32'd0 : ld_data;
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            fault_q     <= 1'b1;
            read_data_q <= '0;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ls_ready  = (state_q == ST_IDLE);
  assign done      = done_q;
  assign fault     = fault_q;
  assign ReadData  = read_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner
// cases and randomized accesses against an arithmetic reference model.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ls_valid = 1'b0;
  logic        ls_ready;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic        done, fault;
  logic [31:0] ReadData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ls_valid(ls_valid), .ls_ready(ls_ready),
    .MemWrite(MemWrite), .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData),
    .done(done), .fault(fault), .ReadData(ReadData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input bit we, input int f3);
    if (we) return f3 <= 2;
    return f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5;
  endfunction

  function automatic int m_size(input int f3);
    return 2 ** (f3 % 4);
  endfunction

  function automatic bit m_fault(input bit we, input int f3, input logic [31:0] addr);
    if (!m_legal(we, f3)) return 1'b1;
    return (addr % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input int f3, input logic [31:0] addr);
    int lane = int'(addr % 4);
    return 4'(((2 ** m_size(f3)) - 1) << lane);
  endfunction

  function automatic logic [31:0] m_wd(input int f3, input logic [31:0] wd);
    case (m_size(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input bit we, input int f3,
                                       input logic [31:0] addr, input logic [31:0] rdata);
    longint bits, v;
    if (we || m_fault(we, f3, addr)) return 32'd0;
    bits = 8 * m_size(f3);
    v = (longint'(rdata) >> (8 * (addr % 4))) & ((64'd1 << bits) - 1);
    if (f3 < 4 && bits < 32 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return 32'(v);
  endfunction

  // ---------------- one access ----------------
  task automatic run_access(input string tag, input bit we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int waits, input bit ack_en,
                            input bit exp_fault, input logic [31:0] exp_rd,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd,
                            input int exp_cyc, input int exp_req);
    int cyc, req_n, done_cyc;
    logic [31:0] g_addr, g_wd;
    logic [3:0]  g_be;
    logic        g_we;
    logic        f_hold;
    logic [31:0] rd_hold;
    g_addr = '0; g_wd = '0; g_be = '0; g_we = 1'b0;
    chk({tag, " ready"}, 32'(ls_ready), 32'd1);
    ls_valid = 1'b1; MemWrite = we; funct3 = f3; ALUResult = addr;
    WriteData = wdata; mem_rdata = rdata;
    @(posedge clk); #1;
    // scramble request inputs so the DUT must rely on what it latched
    ls_valid = 1'b0; MemWrite = ~we; funct3 = ~f3; ALUResult = ~addr; WriteData = ~wdata;
    cyc = 1; req_n = 0; done_cyc = -1;
    while (cyc < 60) begin
      mem_ack = 1'b0;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (mem_req) begin
        if (req_n == 0) begin
          g_addr = mem_addr; g_be = mem_be; g_wd = mem_wdata; g_we = mem_we;
        end
        req_n++;
        if (ack_en && req_n == waits + 1) mem_ack = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_ack = 1'b0;
    chk({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
    chk({tag, " req_cycles"}, 32'(req_n), 32'(exp_req));
    chk({tag, " fault"}, 32'(fault), 32'(exp_fault));
    chk({tag, " ReadData"}, ReadData, exp_rd);
    if (exp_req > 0) begin
      chk({tag, " mem_addr"}, g_addr, addr & 32'hFFFF_FFFC);
      chk({tag, " mem_be"}, 32'(g_be), 32'(exp_be));
      chk({tag, " mem_we"}, 32'(g_we), 32'(we));
      if (we) chk({tag, " mem_wdata"}, g_wd, exp_wd);
    end
    f_hold = fault; rd_hold = ReadData;
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
    chk({tag, " hold"}, {fault, ReadData[30:0]}, {f_hold, rd_hold[30:0]});
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          waits;
    bit          ack_en;
    bit          fault;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] wd;
    int          cyc, req;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF, 4'hF, 32'h0, 2, 1};
    tbl[1]  = '{0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 1, 0, 32'hFFFFFF80, 4'h8, 32'h0, 2, 1};
    tbl[2]  = '{0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 1, 0, 32'h00000080, 4'h8, 32'h0, 2, 1};
    tbl[3]  = '{0, 3'b001, 32'h102, 32'h0, 32'h80015678, 1, 1, 0, 32'hFFFF8001, 4'hC, 32'h0, 3, 2};
    tbl[4]  = '{0, 3'b101, 32'h100, 32'h0, 32'h12348001, 0, 1, 0, 32'h00008001, 4'h3, 32'h0, 2, 1};
    tbl[5]  = '{1, 3'b001, 32'h206, 32'h1234ABCD, 32'hFFFFFFFF, 3, 1, 0, 32'h0, 4'hC, 32'hABCDABCD, 5, 4};
    tbl[6]  = '{1, 3'b000, 32'h1, 32'h000000AB, 32'h0, 1, 1, 0, 32'h0, 4'h2, 32'hABABABAB, 3, 2};
    tbl[7]  = '{0, 3'b010, 32'h101, 32'h0, 32'h55, 0, 1, 1, 32'h0, 4'h0, 32'h0, 1, 0};
    tbl[8]  = '{1, 3'b001, 32'h3, 32'h1, 32'h0, 0, 1, 1, 32'h0, 4'h0, 32'h0, 1, 0};
    tbl[9]  = '{0, 3'b011, 32'h100, 32'h0, 32'h77, 0, 1, 1, 32'h0, 4'h0, 32'h0, 1, 0};
    tbl[10] = '{1, 3'b010, 32'h40, 32'h11223344, 32'h0, 0, 0, 1, 32'h0, 4'hF, 32'h11223344, 17, 16};
    tbl[11] = '{1, 3'b010, 32'h40, 32'h11223344, 32'h0, 15, 1, 0, 32'h0, 4'hF, 32'h11223344, 17, 16};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst ls_ready", 32'(ls_ready), 32'd1);
    chk("rst flags", {28'd0, done, fault, mem_req, mem_we}, 32'd0);
    chk("rst ReadData", ReadData, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i])
      run_access($sformatf("vec%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                 tbl[i].rdata, tbl[i].waits, tbl[i].ack_en, tbl[i].fault, tbl[i].rd,
                 tbl[i].be, tbl[i].wd, tbl[i].cyc, tbl[i].req);

    // reset in the middle of REQ, then a stray ack
    ls_valid = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h10;
    @(posedge clk); #1;
    ls_valid = 1'b0;
    chk("midrst req_up", 32'(mem_req), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("midrst req_drop", 32'(mem_req), 32'd0);
    chk("midrst ready", 32'(ls_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    begin
      logic seen_done;
      seen_done = done;
      repeat (3) begin @(posedge clk); #1; seen_done |= done | mem_req; end
      chk("late_ack ignored", 32'(seen_done), 32'd0);
    end
    run_access("post_rst LW", 1'b0, 3'b010, 32'h200, 32'h0, 32'h0BADC0DE, 0, 1'b1,
               1'b0, 32'h0BADC0DE, 4'hF, 32'h0, 2, 1);

    // randomized accesses against the model
    for (int i = 0; i < 40; i++) begin
      bit          we;
      int          f3, waits;
      logic [31:0] addr, wd, rd;
      bit          flt;
      we    = 1'($urandom_range(0, 1));
      f3    = int'($urandom_range(0, 7));
      addr  = $urandom;
      wd    = $urandom;
      rd    = $urandom;
      waits = int'($urandom_range(0, 4));
      flt   = m_fault(we, f3, addr);
      run_access($sformatf("rnd%0d", i), we, 3'(f3), addr, wd, rd, waits, 1'b1, flt,
                 m_rd(we, f3, addr, rd), m_be(f3, addr), m_wd(f3, wd),
                 flt ? 1 : waits + 2, flt ? 0 : waits + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
